serial_adder: RTL and testbench

//  Bit-serial N-bit adder: the addition counterpart of the team's subtractor cells.
//  It latches two operands plus carry-in on a start request.
//  It adds one bit per clock, LSB first, through a 1-bit full-adder cell and a carry flip-flop.
//  It then presents sum/cout with a one-cycle done pulse.
//  It sits in the datapath library alongside the combinational arithmetic cells.

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/full_add_bit.sv | 13 +
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial arithmetic cells (adder now, subtractor later).
// FSM state encodings are fixed so sibling cells can share decode logic.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_bit.sv
// One-bit full adder cell used by the bit-serial datapath.
module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first, one bit per clock, done pulse on completion.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    state_t           state;
    state_t           state_nx;
    logic [N-1:0]     a_sh;
    logic [N-1:0]     b_sh;
    logic [N-1:0]     res_sh;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic             bit_s;
    logic             bit_co;
    logic             last;
    logic             accept;

    full_add_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign last   = (count == CNT_W'(N - 1));
    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last) state_nx = ST_DONE;
            ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Results are only written on the final RUN edge, never partially.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            count  <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= cin;
            count  <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {bit_s, res_sh[N-1:1]};
            carry  <= bit_co;
            count  <= count + CNT_W'(1);
            if (last) begin
                sum  <= {bit_s, res_sh[N-1:1]};
                cout <= bit_co;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= carry ^ bit_co;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8) against an arithmetic reference model.
// Define SERIAL_ADDER_OVF_EN for both RTL and bench to exercise the ovf output.
module tb_serial_adder;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks;
    int n_fails;

    serial_adder #(.N(N), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {cout,sum} = a + b + cin; signed overflow from operand signs.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic ci, input bit disturb);
        logic [N:0] exp;
        exp = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
        @(negedge clk);
        a = x;
        b = y;
        cin = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            check("done_run", {31'b0, done}, 32'd0);
            if (disturb) begin
                a = N'($urandom);
                b = N'($urandom);
                cin = ~cin;
                start = (i == 3);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_done", {31'b0, busy}, 32'd0);
        check("sum", {24'b0, sum}, {24'b0, exp[N-1:0]});
        check("cout", {31'b0, cout}, {31'b0, exp[N]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'b0, ovf},
              {31'b0, (x[N-1] == y[N-1]) && (exp[N-1] != x[N-1])});
`endif
        @(negedge clk);
        check("done_width", {31'b0, done}, 32'd0);
        check("sum_hold", {24'b0, sum}, {24'b0, exp[N-1:0]});
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        n_checks = 0;
        n_fails  = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", {24'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;

        run_op(8'h3C, 8'h05, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b1);

        // Held start: back-to-back results every N+1 cycles.
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            saw_done = 1'b0;
            while (!saw_done && cyc < 20) begin
                @(negedge clk);
                cyc++;
                saw_done = done;
            end
            check("b2b_period", cyc, 32'd9);
            check("b2b_sum", {24'b0, sum}, 32'h02);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("idle_after_b2b", {30'b0, busy, done}, 32'd0);

        // Reset in the third RUN cycle aborts the operation.
        a = 8'h3C;
        b = 8'h05;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_sum", {24'b0, sum}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        check("abort_quiet", {31'b0, saw_done}, 32'd0);
        run_op(8'h3C, 8'h05, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 30; t++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom),
                   bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
